// File: rtl/instruction_encoder.sv
// Two-stage RV32 instruction encoder: S1 latches a field bundle, S2 holds the packed word.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instruction_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  logic        s1_valid_q;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_funct3_q;
  logic [6:0]  s1_funct7_q;
  logic [31:1] s1_imm_q;
  logic        s1_imm_err;

  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;

  logic        s1_load;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] enc_word;
  logic        enc_err;

  // A stage moves when it is empty or its contents leave in the same cycle.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed through s1_valid_q.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_fmt_q    <= in_fmt;
      s1_opcode_q <= in_opcode;
      s1_rd_q     <= in_rd;
      s1_rs1_q    <= in_rs1;
      s1_rs2_q    <= in_rs2;
      s1_funct3_q <= in_funct3;
      s1_funct7_q <= in_funct7;
      s1_imm_q    <= in_imm[31:1];
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic              imm_bad;
  logic              s1_imm_bad_q;
  logic signed [31:0] simm;

  assign simm = in_imm;

  always_comb begin
    imm_bad = 1'b0;
    case (in_fmt)
      FmtI, FmtS: imm_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      FmtB:       imm_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
      FmtJ:       imm_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
      FmtU:       imm_bad = |in_imm[11:0];
      default:    imm_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_imm_bad_q <= 1'b0;
    end else if (s1_load) begin
      s1_imm_bad_q <= imm_bad;
    end
  end

  assign s1_imm_err = s1_imm_bad_q;
`else
  logic unused_imm_lsb;
  assign unused_imm_lsb = in_imm[0];
  assign s1_imm_err     = 1'b0;
`endif

  always_comb begin
    enc_word = 32'h0;
    enc_err  = s1_imm_err;
    case (s1_fmt_q)
      FmtR: enc_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtI: enc_word = {s1_imm_q[11:1], 1'b0, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FmtS: enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:1], 1'b0,
                        s1_opcode_q};
      FmtB: enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                        s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      FmtU: enc_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      FmtJ: enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q,
                        s1_opcode_q};
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // I and S immediates need bit 0 too; patch it in from the low S1 bit path.
  logic [31:0] enc_word_fix;
  logic        imm_lsb_q;

  always_ff @(posedge clk) begin
    if (s1_load) begin
      imm_lsb_q <= in_imm[0];
    end
  end

  always_comb begin
    enc_word_fix = enc_word;
    if (s1_fmt_q == FmtI) begin
      enc_word_fix[20] = imm_lsb_q;
    end else if (s1_fmt_q == FmtS) begin
      enc_word_fix[7] = imm_lsb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_q <= enc_word_fix;
        s2_err_q   <= enc_err;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;

  logic fire;
  assign fire = s2_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (fire) begin
      if (enc_count != '1) begin
        enc_count <= enc_count + 1'b1;
      end
      if (s2_err_q && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed encodings, backpressure, reset, random traffic.
// Expected error flags follow IMM_RANGE_CHECK_EN when the bench is built with it.
module tb_instruction_encoder;

  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] enc_count;
  logic [CW-1:0] err_count;

  instruction_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_enc    = 0;
  int m_err    = 0;
  int ready_mode = 1;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pack fields by shifting, immediates by bit extraction, range by integer compare.
  function automatic logic [32:0] model(input logic [2:0] fmt, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] base;
    logic        e;
    longint      v;
    v    = longint'($signed(imm));
    base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    e    = 1'b0;
    case (fmt)
      3'd0: w = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: begin
        w = base | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
        e = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = base | (32'(rs2) << 20) | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
        e = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        w = base | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
        e = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
      end
      3'd4: begin
        w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
        e = (imm % 4096) != 0;
      end
      3'd5: begin
        w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
            | (((imm >> 11) & 1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 20) & 1) << 31);
        e = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    if (fmt <= 3'd5) e = e && RangeCheck;
    return {e, w};
  endfunction

  task automatic monitor();
    logic        stall = 1'b0;
    logic [31:0] p_instr = '0;
    logic        p_err = 1'b0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_enc = 0;
        m_err = 0;
        stall = 1'b0;
        continue;
      end
      check("enc_count", 32'(enc_count), 32'(m_enc));
      check("err_count", 32'(err_count), 32'(m_err));
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_instr", out_instr, p_instr);
        check("hold_err", 32'(out_err), 32'(p_err));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h expected none", out_instr);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", out_instr, e[31:0]);
          check("out_err", 32'(out_err), 32'(e[32]));
        end
        if (m_enc < CMAX) m_enc++;
        if (out_err && m_err < CMAX) m_err++;
      end
      stall   = out_valid && !out_ready;
      p_instr = out_instr;
      p_err   = out_err;
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the bundle.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic [32:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    send(fmt, op, rd, rs1, rs2, f3, f7, imm, model(fmt, op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [2:0]  fmt;
    logic [31:0] imm;
    fork
      monitor();
      ready_driver();
    join_none

    do_reset();

    // Directed encodings, first one also checks two-cycle latency.
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, {1'b0, 32'h003100B3});
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd10, {1'b0, 32'h00A10093});
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'd8, {1'b0, 32'h00112423});
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16, {1'b0, 32'h00208863});
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd17, {RangeCheck, 32'h00208863});
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd32, {1'b0, 32'h020000EF});
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, {1'b0, 32'h123450B7});
    send(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'hDEADBEEF, {1'b1, 32'h00000000});
    wait_drain();
    check("dir_enc_count", 32'(enc_count), 32'd8);
    check("dir_err_count", 32'(err_count), RangeCheck ? 32'd2 : 32'd1);

    // Backpressure: two bundles fill the pipe, the third waits.
    do_reset();
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_m(3'd1, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd100);
    send_m(3'd0, 7'h33, 5'd6, 5'd7, 5'd8, 3'd0, 7'h20, 32'd0);
    @(negedge clk);
    check("bp_in_ready_a", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_in_ready_b", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    send_m(3'd2, 7'h23, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, 32'hFFFFFFFC);
    wait_drain();
    check("bp_enc_count", 32'(enc_count), 32'd3);

    // Reset with two words stalled in the pipe; neither may appear afterwards.
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_m(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    send_m(3'd1, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
    do_reset();
    ready_mode = 1;
    repeat (8) @(posedge clk);
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_enc_count", 32'(enc_count), 32'd0);

    // Random traffic with random backpressure; counters saturate along the way.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      if (fmt == 3'd4 && $urandom_range(0, 1) == 1) imm = imm & 32'hFFFFF000;
      send_m(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             7'($urandom), imm);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
